// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, prescale constants and helpers for the UART receive control block
package uart_pkg;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PEND  = 2'd1,
    C_APPLY = 2'd2
  } cfg_state_e;

  localparam logic [5:0] PRESC_4  = 6'd4;
  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  // The receiver sampler only supports these oversampling ratios.
  function automatic logic presc_legal(input logic [5:0] p);
    return (p == PRESC_4) || (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

  // Saturating event counter step; a clear still records an event of the same cycle.
  function automatic logic [7:0] err_cnt_next(input logic [7:0] cnt, input logic ev, input logic clr);
    if (clr)
      return {7'd0, ev};
    else if (ev && (cnt != 8'hFF))
      return cnt + 8'd1;
    else
      return cnt;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - small receive FIFO with a registered head output
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;

  logic             do_pop;
  logic             do_push;
  logic [AW:0]      cnt_after_pop;
  logic [AW:0]      cnt_next;
  logic [AW-1:0]    rd_ptr_next;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;

  // A push into a full FIFO only fits when the head leaves in the same cycle.
  always_comb begin
    do_pop        = pop & ~empty;
    do_push       = push & (~full | do_pop);
    cnt_after_pop = cnt - {{AW{1'b0}}, do_pop};
    cnt_next      = cnt_after_pop + {{AW{1'b0}}, do_push};
    rd_ptr_next   = rd_ptr + {{(AW-1){1'b0}}, do_pop};
  end

  // Storage array, written at the tail; no reset needed for payload.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and the registered head; the head bypasses storage when the pushed byte becomes the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      rd_ptr     <= rd_ptr_next;
      wr_ptr     <= wr_ptr + {{(AW-1){1'b0}}, do_push};
      cnt        <= cnt_next;
      head_valid <= (cnt_next != '0);
      if (cnt_next != '0)
        head_data <= (cnt_after_pop == '0) ? wdata : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver config owner, byte buffer and error counters
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int RST_PRESCALE = 8,
  parameter bit RST_PAR_EN   = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   cfg_wr,
  input  logic [5:0]             cfg_prescale,
  input  logic                   cfg_par_en,
  output logic                   cfg_ack,
  output logic                   cfg_err,
  output logic                   cfg_pend,
  output logic [5:0]             prescale,
  output logic                   par_en,
  input  logic                   rx_busy,
  output logic                   rx_hold,
  input  logic                   rx_data_valid,
  input  logic [7:0]             rx_p_data,
  input  logic                   rx_par_err,
  input  logic                   rx_stp_err,
  input  logic                   rx_glitch,
  output logic                   m_valid,
  output logic [7:0]             m_data,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   overrun,
  input  logic                   ovr_clr,
  output logic [7:0]             par_err_cnt,
  output logic [7:0]             stp_err_cnt,
  output logic [7:0]             glitch_cnt,
  input  logic                   cnt_clr
);

  cfg_state_e state;
  logic [5:0] sh_prescale;
  logic       sh_par_en;

  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  // Config handshake: requests wait out any frame in progress and hold the line idle until applied.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= C_IDLE;
      sh_prescale <= 6'(RST_PRESCALE);
      sh_par_en   <= RST_PAR_EN;
      prescale    <= 6'(RST_PRESCALE);
      par_en      <= RST_PAR_EN;
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_pend    <= 1'b0;
      rx_hold     <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        C_IDLE: begin
          if (cfg_wr) begin
            if (presc_legal(cfg_prescale)) begin
              sh_prescale <= cfg_prescale;
              sh_par_en   <= cfg_par_en;
              cfg_pend    <= 1'b1;
              rx_hold     <= 1'b1;
              state       <= C_PEND;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        C_PEND: begin
          if (!rx_busy) begin
            prescale <= sh_prescale;
            par_en   <= sh_par_en;
            cfg_ack  <= 1'b1;
            cfg_pend <= 1'b0;
            state    <= C_APPLY;
          end
        end
        C_APPLY: begin
          rx_hold <= 1'b0;
          state   <= C_IDLE;
        end
        default: begin
          cfg_pend <= 1'b0;
          rx_hold  <= 1'b0;
          state    <= C_IDLE;
        end
      endcase
    end
  end

  // Pop is qualified by both the registered head flag and the live occupancy.
  assign pop = m_valid & m_ready & ~fifo_empty;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (rx_data_valid),
    .wdata      (rx_p_data),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_cnt),
    .head_valid (m_valid),
    .head_data  (m_data)
  );

  // Sticky overrun: a dropped byte outranks a clear in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      overrun <= 1'b0;
    else if (rx_data_valid && fifo_full && !pop)
      overrun <= 1'b1;
    else if (ovr_clr)
      overrun <= 1'b0;
  end

  // Saturating receive error counters with a shared clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_err_cnt <= 8'd0;
      stp_err_cnt <= 8'd0;
      glitch_cnt  <= 8'd0;
    end else begin
      par_err_cnt <= err_cnt_next(par_err_cnt, rx_par_err, cnt_clr);
      stp_err_cnt <= err_cnt_next(stp_err_cnt, rx_stp_err, cnt_clr);
      glitch_cnt  <= err_cnt_next(glitch_cnt, rx_glitch, cnt_clr);
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Control and buffering block that sits between the UART receiver (FSM, sampler, deserializer, checkers) and the system bus side.
- Owns the receiver's live configuration (prescale, parity enable) and applies updates only between frames.
- Buffers received bytes in a small FIFO with a valid/ready output, tracks overrun, and keeps saturating error counters.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, range 2..16.
- RST_PRESCALE, 8, prescale value loaded at reset.
- RST_PAR_EN, 0, parity enable loaded at reset.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- cfg_wr  in  1  one-cycle configuration update request.
- cfg_prescale  in  6  requested prescale; legal values 4, 8, 16, 32.
- cfg_par_en  in  1  requested parity enable.
- cfg_ack  out  1  one-cycle pulse when the new config is applied.
- cfg_err  out  1  one-cycle pulse when a request is rejected.
- cfg_pend  out  1  high while an accepted request waits to apply.
- prescale  out  6  live prescale driven to the receiver.
- par_en  out  1  live PAR_EN driven to the receiver.
- rx_busy  in  1  receiver is mid-frame (its edge_bit_cnt_en).
- rx_hold  out  1  top level forces the receiver's RX_IN to 1 while this is high, which blocks frame starts.
- rx_data_valid  in  1  one-cycle pulse, byte complete.
- rx_p_data  in  8  received byte, valid with rx_data_valid.
- rx_par_err  in  1  one-cycle parity error event.
- rx_stp_err  in  1  one-cycle stop error event.
- rx_glitch  in  1  one-cycle start glitch event.
- m_valid  out  1  FIFO head valid.
- m_data  out  8  FIFO head byte.
- m_ready  in  1  consumer accepts the head.
- fifo_cnt  out  $clog2(DEPTH)+1  occupancy.
- overrun  out  1  sticky; a byte was dropped.
- ovr_clr  in  1  clears overrun.
- par_err_cnt  out  8  saturating count.
- stp_err_cnt  out  8  saturating count.
- glitch_cnt  out  8  saturating count.
- cnt_clr  in  1  clears all three counters.

Behaviour:
- Reset values:
  - prescale = RST_PRESCALE, par_en = RST_PAR_EN.
  - cfg_ack, cfg_err, cfg_pend, rx_hold, m_valid, overrun = 0.
  - m_data = 0, fifo_cnt = 0, all counters = 0.
  - Config FSM in C_IDLE; FIFO empty.
  - Reset mid-frame or mid-request discards everything.
- Config FSM states: C_IDLE, C_PEND, C_APPLY.
  - C_IDLE + cfg_wr with illegal cfg_prescale: cfg_err pulses next cycle; live config unchanged; stay in C_IDLE.
  - C_IDLE + cfg_wr with legal cfg_prescale: latch shadow regs; go to C_PEND.
  - C_PEND: cfg_pend=1 and rx_hold=1. Go to C_APPLY on the first cycle rx_busy=0.
  - C_APPLY (1 cycle): prescale/par_en <= shadow; cfg_ack=1; rx_hold=1; then C_IDLE.
  - cfg_wr while in C_PEND/C_APPLY is ignored, with no cfg_err.
  - Latency with rx_busy=0 throughout: cfg_wr at cycle N -> cfg_ack and new prescale/par_en visible at N+2. rx_hold is high in N+1 and N+2.
- FIFO:
  - Push on rx_data_valid; m_valid/m_data are registered, so a push at cycle N into an empty FIFO gives m_valid=1 at N+1.
  - Pop when m_valid & m_ready; the next entry appears on the next cycle.
  - Push is accepted if not full, or if full and popping in the same cycle; occupancy is then unchanged.
  - Push while full without a pop drops the byte and sets overrun. ovr_clr clears it; a set in the same cycle as ovr_clr wins.
  - Pointers wrap modulo DEPTH; fifo_cnt ranges 0..DEPTH.
- Counters:
  - Each increments on its event pulse and saturates at 255.
  - cnt_clr in the same cycle as an event gives 1 for that counter; other counters give 0.
  - Error events do not push into the FIFO.

Decomposition:
- Package uart_pkg holds:
  - cfg_state_e enum (C_IDLE, C_PEND, C_APPLY);
  - legal prescale constants PRESC_4/8/16/32;
  - function presc_legal().
- Sub-module uart_rx_fifo (parameter DEPTH, WIDTH=8) provides:
  - push and pop;
  - full, empty and count;
  - registered head output.

Test Plan:
- Reset, then cfg_wr prescale=16 par_en=1 with rx_busy=0 -> cfg_ack at +2 cycles, prescale=16, par_en=1, rx_hold high for 2 cycles.
- cfg_wr prescale=12 -> cfg_err pulse, prescale stays 8, cfg_pend=0.
- rx_busy=1 for 20 cycles, cfg_wr prescale=32 at cycle 3 -> cfg_pend high until rx_busy falls, cfg_ack one cycle later; a second cfg_wr during C_PEND is ignored.
- m_ready=0, push 0x11,0x22,0x33,0x44,0x55 (DEPTH=4) -> fifo_cnt=4, overrun=1; drain yields 0x11..0x44 in order; ovr_clr -> overrun=0.
- FIFO full, rx_data_valid and pop in the same cycle with byte 0xA5 -> fifo_cnt stays 4, no overrun, 0xA5 is the last byte out.
- 300 rx_stp_err pulses -> stp_err_cnt=255; cnt_clr together with one rx_stp_err -> stp_err_cnt=1, par_err_cnt=0.
